// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: owns the shared memory bus between the CPU and the OAM DMA.
// A CPU write to DMA_REG_ADDR latches the source page and starts a DMA_LEN
// byte copy from {src,8'h00} to DST_BASE, alternating one read and one write
// cycle per byte. While a copy runs, CPU HRAM accesses own the bus and stall
// the copy. Every other CPU access is blocked: reads return 8'hFF and writes
// are dropped.
// Ports:
//   clock, reset            clock, async active-low reset
//   cpu_addr/wdata/we/re    CPU request; cpu_rdata returns read data
//   mem_addr/wdata/we/re    bus to memory; mem_rdata is combinational
//   dma_active              high while a copy is in SETUP/RD/WR
//   dma_src                 current source page register
module dma_bus_arbiter #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_src
);

  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, SETUP, RD, WR} state_t;

  state_t     state, state_nxt;
  logic [7:0] src_reg, idx, idx_nxt, byte_buf, byte_buf_nxt;
  logic       active_q;
  logic       hit_reg, hit_hram, cpu_own, reg_wr;

  assign hit_reg  = (cpu_addr == DMA_REG_ADDR);
  assign hit_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign cpu_own  = (cpu_re | cpu_we) && hit_hram;
  assign reg_wr   = cpu_we && hit_reg;

  // Next state. A register write restarts from SETUP in any state; otherwise
  // a CPU HRAM cycle freezes the copy in place.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    byte_buf_nxt = byte_buf;
    if (reg_wr) begin
      state_nxt = SETUP;
      idx_nxt   = '0;
    end else if (!cpu_own) begin
      case (state)
        SETUP: begin
          state_nxt = RD;
          idx_nxt   = '0;
        end
        RD: begin
          state_nxt    = WR;
          byte_buf_nxt = mem_rdata;
        end
        WR: begin
          idx_nxt   = idx + 8'd1;
          state_nxt = (idx == LAST) ? IDLE : RD;
        end
        default: ;
      endcase
    end
  end

  // Bus mux. Idle bus cycles still present cpu_addr with both strobes low.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_rdata = 8'hFF;
    if (hit_reg)
      cpu_rdata = src_reg;
    if (state == IDLE || cpu_own) begin
      mem_we = cpu_we & ~hit_reg;
      mem_re = cpu_re & ~hit_reg;
      if (!hit_reg)
        cpu_rdata = mem_rdata;
    end else if (!reg_wr) begin
      // On a restart cycle the copy issues nothing; the buffered byte is lost.
      case (state)
        RD: begin
          mem_addr = {src_reg, idx};
          mem_re   = 1'b1;
        end
        WR: begin
          mem_addr  = DST_BASE + {8'h00, idx};
          mem_wdata = byte_buf;
          mem_we    = 1'b1;
        end
        default: ;
      endcase
    end
    // Strobes must be dead the instant reset asserts, even mid-cycle.
    if (!reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      src_reg  <= 8'h00;
      idx      <= 8'h00;
      byte_buf <= 8'h00;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      byte_buf <= byte_buf_nxt;
      active_q <= (state_nxt != IDLE);
      if (reg_wr)
        src_reg <= cpu_wdata;
    end
  end

  assign dma_active = active_q;
  assign dma_src    = src_reg;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter. A flat 64 KiB memory sits on the
// mem_* side; ref_mem holds what memory should contain, updated from the
// block's rules (copy page to OAM, HRAM writes land, blocked writes vanish).
module tb_dma_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [7:0]  dma_src;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  int errors = 0;
  int checks = 0;

  dma_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .dma_active(dma_active), .dma_src(dma_src)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Fill memory through the CPU passthrough while the arbiter is idle.
  task automatic preload(input logic [15:0] base, input int len, input int kind);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = (kind == 0) ? (8'(i) ^ 8'h5A) : 8'($urandom);
      @(negedge clock);
      cpu_addr = base + 16'(i); cpu_wdata = d; cpu_we = 1'b1; cpu_re = 1'b0;
      ref_mem[base + 16'(i)] = d;
    end
    @(negedge clock);
    cpu_we = 1'b0;
  endtask

  // Starts a copy from the given page; returns just after the capturing edge.
  task automatic start_dma(input logic [7:0] page);
    @(negedge clock);
    cpu_addr = 16'hFF46; cpu_wdata = page; cpu_we = 1'b1; cpu_re = 1'b0;
    @(negedge clock);
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      cpu_we = (k == 0) ? 1'b1 : 1'($urandom);
      cpu_re = (k == 0) ? 1'b1 : 1'($urandom);
      #3;
      checks++;
      if (dma_active !== 1'b0 || dma_src !== 8'h00) begin
        errors++;
        $display("FAIL reset_regs: dma_active=%b dma_src=%02h want 0/00", dma_active, dma_src);
      end
      checks++;
      if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobes: mem_we=%b mem_re=%b want 0/0", mem_we, mem_re);
      end
    end
    @(negedge clock);
    cpu_we = 1'b0; cpu_re = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    cpu_addr = 16'hC123; cpu_wdata = 8'h42; cpu_we = 1'b1;
    ref_mem[16'hC123] = 8'h42;
    @(negedge clock);
    cpu_we = 1'b0; cpu_re = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 16'hC123 || mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_rdata !== 8'h42) begin
      errors++;
      $display("FAIL reset_passthru: addr=%04h re=%b we=%b rdata=%02h want C123/1/0/42",
               mem_addr, mem_re, mem_we, cpu_rdata);
    end
    @(negedge clock);
    cpu_re = 1'b0;
  endtask

  task automatic test_basic_copy();
    int n, bad, first;
    @(negedge clock);
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC0; cpu_we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reg_not_forwarded: mem_we=%b want 0", mem_we);
    end
    @(negedge clock);
    cpu_we = 1'b0;
    n = 0;
    while (dma_active && n < 2000) begin
      n++;
      cpu_re = 1'b0; cpu_we = 1'b0;
      if (n == 50) begin cpu_addr = 16'hC000; cpu_re = 1'b1; end
      if (n == 51) begin cpu_addr = 16'hD000; cpu_wdata = 8'h77; cpu_we = 1'b1; end
      #1;
      if (n == 2) begin
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'hC000) begin
          errors++;
          $display("FAIL basic_rd0: re=%b addr=%04h want 1/C000", mem_re, mem_addr);
        end
      end
      if (n == 3) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'hFE00 || mem_wdata !== 8'h5A) begin
          errors++;
          $display("FAIL basic_wr0: we=%b addr=%04h data=%02h want 1/FE00/5A",
                   mem_we, mem_addr, mem_wdata);
        end
      end
      if (n == 50) begin
        checks++;
        if (cpu_rdata !== 8'hFF) begin
          errors++;
          $display("FAIL blocked_read: rdata=%02h want FF", cpu_rdata);
        end
      end
      @(negedge clock);
    end
    cpu_re = 1'b0; cpu_we = 1'b0;
    checks++;
    if (n != 321) begin
      errors++;
      $display("FAIL basic_len: active cycles=%0d want 321", n);
    end
    bad = 0; first = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) begin
        if (bad == 0) first = i;
        bad++;
      end
    for (int i = 0; i < 160; i++) ref_mem[16'hFE00 + i] = ref_mem[16'hC000 + i];
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_oam: %0d bytes wrong, first idx %0d got %02h want %02h",
               bad, first, mem[16'hFE00 + first], 8'(first) ^ 8'h5A);
    end
    checks++;
    if (mem[16'hFEA0] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_fea0: got %02h want A5", mem[16'hFEA0]);
    end
    checks++;
    if (mem[16'hD000] !== ref_mem[16'hD000]) begin
      errors++;
      $display("FAIL blocked_write: mem[D000]=%02h want %02h", mem[16'hD000], ref_mem[16'hD000]);
    end
    cpu_addr = 16'hFF46; cpu_re = 1'b1;
    #1;
    checks++;
    if (cpu_rdata !== 8'hC0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL reg_read: rdata=%02h mem_re=%b want C0/0", cpu_rdata, mem_re);
    end
    @(negedge clock);
    cpu_re = 1'b0;
  endtask

  task automatic test_hram_priority();
    int n, bad;
    start_dma(8'h90);
    n = 0;
    while (dma_active && n < 2000) begin
      n++;
      cpu_re = 1'b0; cpu_we = 1'b0;
      if (n >= 22 && n <= 24) begin cpu_addr = 16'hFF90; cpu_wdata = 8'h3C; cpu_we = 1'b1; end
      #1;
      if (n >= 22 && n <= 24) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'hFF90 || mem_wdata !== 8'h3C) begin
          errors++;
          $display("FAIL hram_pass n=%0d: we=%b addr=%04h data=%02h want 1/FF90/3C",
                   n, mem_we, mem_addr, mem_wdata);
        end
      end
      if (n == 25) begin
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'h900A) begin
          errors++;
          $display("FAIL hram_resume: re=%b addr=%04h want 1/900A", mem_re, mem_addr);
        end
      end
      @(negedge clock);
    end
    cpu_we = 1'b0;
    ref_mem[16'hFF90] = 8'h3C;
    for (int i = 0; i < 160; i++) ref_mem[16'hFE00 + i] = ref_mem[16'h9000 + i];
    checks++;
    if (n != 324) begin
      errors++;
      $display("FAIL hram_len: active cycles=%0d want 324", n);
    end
    checks++;
    if (mem[16'hFF90] !== 8'h3C) begin
      errors++;
      $display("FAIL hram_data: mem[FF90]=%02h want 3C", mem[16'hFF90]);
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== ref_mem[16'hFE00 + i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hram_oam: %0d bytes wrong want 0", bad);
    end
  endtask

  task automatic test_restart();
    int n, bad;
    start_dma(8'hC0);
    n = 0;
    while (dma_active && n < 2000) begin
      n++;
      cpu_re = 1'b0; cpu_we = 1'b0;
      if (n == 100) begin cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_we = 1'b1; end
      #1;
      @(negedge clock);
    end
    cpu_we = 1'b0;
    for (int i = 0; i < 160; i++) ref_mem[16'hFE00 + i] = ref_mem[16'hD000 + i];
    checks++;
    if (n != 100 + 321) begin
      errors++;
      $display("FAIL restart_len: active cycles=%0d want 421", n);
    end
    checks++;
    if (dma_src !== 8'hD0) begin
      errors++;
      $display("FAIL restart_src: dma_src=%02h want D0", dma_src);
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== ref_mem[16'hFE00 + i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_oam: %0d bytes wrong want 0", bad);
    end
  endtask

  task automatic test_random();
    logic [7:0]  pages [5];
    logic [7:0]  src, d;
    logic [15:0] a;
    int n, stalls, act, bad;
    pages = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    for (int t = 0; t < 3; t++) begin
      src = pages[$urandom_range(4, 0)];
      start_dma(src);
      n = 0; stalls = 0;
      while (dma_active && n < 3000) begin
        n++;
        cpu_re = 1'b0; cpu_we = 1'b0;
        act = (n >= 2 && n <= 300) ? int'($urandom_range(15, 0)) : 15;
        a = 16'hFF80 + 16'($urandom_range(126, 0));
        d = 8'($urandom);
        case (act)
          0, 1: begin
            cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
            ref_mem[a] = d; stalls++;
          end
          2: begin cpu_addr = a; cpu_re = 1'b1; stalls++; end
          3: begin cpu_addr = 16'h9000 + 16'($urandom_range(255, 0)); cpu_re = 1'b1; end
          4: begin cpu_addr = 16'h9000 + 16'($urandom_range(255, 0)); cpu_wdata = d; cpu_we = 1'b1; end
          5: begin cpu_addr = 16'hFF46; cpu_re = 1'b1; end
          default: ;
        endcase
        #1;
        if (act == 2) begin
          checks++;
          if (cpu_rdata !== ref_mem[a]) begin
            errors++;
            $display("FAIL rnd_hram_read %04h: got %02h want %02h", a, cpu_rdata, ref_mem[a]);
          end
        end
        if (act == 3) begin
          checks++;
          if (cpu_rdata !== 8'hFF) begin
            errors++;
            $display("FAIL rnd_blocked_read: got %02h want FF", cpu_rdata);
          end
        end
        if (act == 5) begin
          checks++;
          if (cpu_rdata !== src) begin
            errors++;
            $display("FAIL rnd_reg_read: got %02h want %02h", cpu_rdata, src);
          end
        end
        @(negedge clock);
      end
      cpu_re = 1'b0; cpu_we = 1'b0;
      for (int i = 0; i < 160; i++) ref_mem[16'hFE00 + i] = ref_mem[{src, 8'(i)}];
      checks++;
      if (n != 321 + stalls) begin
        errors++;
        $display("FAIL rnd_len src=%02h: active cycles=%0d want %0d", src, n, 321 + stalls);
      end
      bad = 0;
      for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== ref_mem[16'hFE00 + i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_oam src=%02h: %0d bytes wrong want 0", src, bad);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[16'h9000 + i] !== ref_mem[16'h9000 + i]) bad++;
      for (int i = 16'hFF80; i <= 16'hFFFE; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_mem src=%02h: %0d bytes wrong want 0", src, bad);
      end
    end
  endtask

  task automatic test_async_reset();
    int n, bad;
    start_dma(8'hC0);
    n = 0;
    while (dma_active && n < 3) begin
      n++;
      #1;
      if (n < 3) @(negedge clock);
    end
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: mem_we=%b want 1 in WR", mem_we);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: we=%b re=%b active=%b want 0/0/0", mem_we, mem_re, dma_active);
    end
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mem_we !== 1'b0 || mem_re !== 1'b0 || dma_active !== 1'b0 || dma_src !== 8'h00) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL areset_after: %0d cycles with activity want 0", bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload(16'hC000, 256, 0);
    preload(16'hD000, 256, 1);
    preload(16'h9000, 256, 1);
    preload(16'hA000, 256, 1);
    preload(16'hB000, 256, 1);
    preload(16'hFF80, 127, 1);
    preload(16'hFEA0, 1, 1);
    @(negedge clock);
    cpu_addr = 16'hFEA0; cpu_wdata = 8'hA5; cpu_we = 1'b1;
    ref_mem[16'hFEA0] = 8'hA5;
    @(negedge clock);
    cpu_we = 1'b0;
    test_basic_copy();
    test_hram_priority();
    test_restart();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
Name:
dma_bus_arbiter

Overview:
- Owns the single shared memory bus between the CPU and the OAM DMA engine.
- Decodes CPU writes to the DMA register (0xFF46) and sequences a 160-byte copy from {src_hi,8'h00} to 0xFE00.
- While the copy runs, it arbitrates the bus: CPU HRAM accesses take priority and stall DMA, and all other CPU accesses are blocked.
- Sits between the cpu core and mem, replacing direct cpu-to-mem wiring.

Parameters:
- DMA_LEN, 160, number of bytes per transfer.
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- DST_BASE, 16'hFE00, OAM destination base address.
- HRAM_LO, 16'hFF80, lowest CPU address still accessible during DMA.
- HRAM_HI, 16'hFFFE, highest CPU address still accessible during DMA.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_addr  input  16  CPU bus address.
- cpu_wdata  input  8  CPU write data.
- cpu_we  input  1  CPU write strobe.
- cpu_re  input  1  CPU read strobe.
- cpu_rdata  output  8  read data returned to CPU.
- mem_addr  output  16  address to mem.
- mem_wdata  output  8  write data to mem.
- mem_we  output  1  mem write strobe.
- mem_re  output  1  mem read strobe.
- mem_rdata  input  8  mem read data, valid combinationally in the same cycle as mem_re.
- dma_active  output  1  high while a transfer is in progress (SETUP/RD/WR).
- dma_src  output  8  current DMA source register value.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, src_reg=8'h00, idx=0, buf=8'h00, dma_active=0.
  - mem_we=0 and mem_re=0 are forced while reset is low.
- hit_reg = cpu_addr==DMA_REG_ADDR.
- hit_hram = HRAM_LO<=cpu_addr<=HRAM_HI.
- DMA register:
  - cpu_we&&hit_reg loads src_reg at posedge in any state.
  - The access is never forwarded to mem.
  - cpu_re&&hit_reg returns src_reg on cpu_rdata.
- States: IDLE, SETUP, RD, WR.
- IDLE:
  - Combinational passthrough: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we&~hit_reg, mem_re=cpu_re&~hit_reg, cpu_rdata=mem_rdata (src_reg on hit_reg).
  - A register write moves to SETUP next cycle.
- SETUP:
  - One idle bus cycle; idx=0.
  - Goes to RD unless stalled.
- RD:
  - mem_addr={src_reg,idx[7:0]}, mem_re=1; buf<=mem_rdata at posedge.
  - Then WR.
- WR:
  - mem_addr=DST_BASE+idx, mem_wdata=buf, mem_we=1.
  - idx<=idx+1.
  - If idx==DMA_LEN-1, go to IDLE; else go to RD.
- Arbitration in SETUP/RD/WR:
  - If (cpu_re|cpu_we)&&hit_hram, the CPU owns the bus that cycle with passthrough as in IDLE.
  - The DMA state, idx and buf hold (stall one cycle per CPU HRAM cycle).
- Blocked CPU accesses in SETUP/RD/WR:
  - Non-HRAM, non-register CPU reads return 8'hFF.
  - Non-HRAM, non-register CPU writes are dropped (never reach mem).
- Restart: a register write while in SETUP/RD/WR loads the new src_reg, resets idx to 0 and enters SETUP. Any buffered byte is discarded.
- Timing:
  - dma_active is registered from state (high in SETUP/RD/WR).
  - An unstalled transfer occupies 1+2*DMA_LEN = 321 cycles, from the cycle after the register write.
- Address widths:
  - Source address is {src_reg, idx[7:0]}, with no wrap handling needed since idx<=159.
  - src_reg values 0xE0..0xFF are used as-is.
- Async reset mid-transfer aborts immediately; OAM is left partially written; no further mem strobes occur.

Test Plan:
- Reset state: drive reset low with random CPU inputs -> dma_active=0, dma_src=8'h00, mem_we=0, mem_re=0; after release, a CPU read of 0xC123 passes through with mem_addr=16'hC123.
- Basic copy:
  - Preload 0xC000..0xC09F with i^8'h5A, then CPU writes 8'hC0 to 0xFF46.
  - Expect dma_active high for exactly 321 cycles, FE00+i==i^8'h5A for all i<160, and FEA0 unchanged.
  - Expect a subsequent read of 0xFF46 to return 8'hC0.
- Blocking: during the transfer, a CPU read of 0xC000 returns 8'hFF and a CPU write of 8'h77 to 0xD000 leaves mem[D000] unchanged.
- HRAM priority:
  - During RD at idx=10, the CPU writes 8'h3C to 0xFF90 for 3 cycles.
  - Expect mem[FF90]=8'h3C, dma_active high for 324 cycles, and the OAM copy still correct.
- Restart: write 8'hC0 to FF46, then write 8'hD0 at cycle 100 -> dma_active stays high through 321 further cycles; final OAM equals D000..D09F.
- Async reset: assert reset mid-WR, between clock edges -> mem_we drops immediately, state is IDLE, and dma_active=0 after release.
